// File: rtl/seq_detector_param_if.sv
// Serial bit-stream bundle for seq_detector_param: qualified data, mode/clear
// controls going in, match strobes, counter and progress coming back.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int PW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

  logic             din_valid;
  logic             din;
  logic             overlap;
  logic             cnt_clr;
  logic             match;
  logic             match_q;
  logic [CNT_W-1:0] match_count;
  logic [PW-1:0]    progress;

  modport master (
    output din_valid, din, overlap, cnt_clr,
    input  match, match_q, match_count, progress
  );

  modport slave (
    input  din_valid, din, overlap, cnt_clr,
    output match, match_q, match_count, progress
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: KMP automaton built from PATTERN at
// elaboration, Mealy and registered match outputs, saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_detector_param_if.slave bus
);

  localparam int PW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam int TABN = 2 ** PW;

  // Longest pattern prefix (shorter than PAT_LEN) that ends the stream formed
  // by the first k pattern bits followed by b; k = PAT_LEN-1 with the final
  // pattern bit yields the pattern's longest proper border.
  function automatic int kmpNext(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    if (k >= PAT_LEN) return 0;
    for (int l = 1; l < PAT_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          idx = k + 1 - l + j;
          sb  = (idx == k) ? b : PATTERN[PAT_LEN-1-idx];
          if (sb != PATTERN[PAT_LEN-1-j]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  localparam logic [PW-1:0]    LAST    = PW'(PAT_LEN - 1);
  localparam logic [PW-1:0]    BORDER  = PW'(kmpNext(PAT_LEN - 1, PATTERN[0]));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    nextTab [2*TABN];
  logic [PW-1:0]    progress;
  logic [PW-1:0]    nextProgress;
  logic             hit;
  logic             matchQ;
  logic [CNT_W-1:0] matchCount;

  // Unreachable encodings (progress >= PAT_LEN) fall back to state 0.
  for (genvar k = 0; k < TABN; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NX = kmpNext(k, b[0]);
      assign nextTab[2*k+b] = PW'(NX);
    end
  end

  always_comb begin
    hit          = bus.din_valid & (progress == LAST) & (bus.din == PATTERN[0]);
    nextProgress = progress;
    if (bus.din_valid) begin
      if (hit) nextProgress = bus.overlap ? BORDER : '0;
      else     nextProgress = nextTab[{progress, bus.din}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      progress   <= '0;
      matchQ     <= 1'b0;
      matchCount <= '0;
    end else begin
      progress <= nextProgress;
      matchQ   <= hit;
      if (bus.cnt_clr)
        matchCount <= '0;
      else if (hit && (matchCount != CNT_MAX))
        matchCount <= matchCount + 1'b1;
    end
  end

  assign bus.match       = hit & ~reset;
  assign bus.match_q     = matchQ;
  assign bus.match_count = matchCount;
  assign bus.progress    = progress;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, randomized run against a
// sliding-window model, and a saturation check on a 2-bit counter instance.
module tb_seq_detector_param;

  localparam logic [3:0] PAT = 4'b1011;

  typedef struct {
    bit rst;
    bit vld;
    bit d;
    bit ovl;
    bit clr;
    bit expMatch;
    bit expMatchQ;
    int expProg;
    int expCount;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic resetB;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[$];
  bit   mHist[$];
  int   mCount;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) busA ();
  seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) busB ();

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave)
  );

  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dutB (
    .clk(clk), .reset(resetB), .bus(busB.slave)
  );

  function automatic vec_t mk(bit rst, bit vld, bit d, bit ovl, bit clr,
                              bit m, bit mq, int p, int c);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d; v.ovl = ovl; v.clr = clr;
    v.expMatch = m; v.expMatchQ = mq; v.expProg = p; v.expCount = c;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    busA.din_valid = v.vld;
    busA.din       = v.d;
    busA.overlap   = v.ovl;
    busA.cnt_clr   = v.clr;
  endtask

  task automatic runCycle(input vec_t v, input string tag);
    applyStimulus(v);
    #3;
    checkOutput({tag, " match"}, int'(busA.match), int'(v.expMatch));
    @(posedge clk);
    #1;
    checkOutput({tag, " progress"}, int'(busA.progress), v.expProg);
    checkOutput({tag, " match_q"}, int'(busA.match_q), int'(v.expMatchQ));
    checkOutput({tag, " match_count"}, int'(busA.match_count), v.expCount);
  endtask

  // Reference: keep the recent accepted bits; a match is the last four bits
  // spelling the pattern, progress is the longest pattern prefix ending the window.
  task automatic modelStep(inout vec_t v);
    bit hit;
    int best;
    bit ok;
    hit = 1'b0;
    if (v.rst) begin
      mHist.delete();
      mCount = 0;
    end else begin
      if (v.vld) begin
        mHist.push_back(v.d);
        if (mHist.size() >= 4) begin
          hit = 1'b1;
          for (int j = 0; j < 4; j++)
            if (mHist[mHist.size()-4+j] != PAT[3-j]) hit = 1'b0;
        end
        if (hit && !v.ovl) mHist.delete();
        while (mHist.size() > 3) void'(mHist.pop_front());
      end
      if (v.clr) mCount = 0;
      else if (hit && mCount < 255) mCount++;
    end
    best = 0;
    for (int l = 1; l <= 3; l++) begin
      if (l <= mHist.size()) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++)
          if (mHist[mHist.size()-l+j] != PAT[3-j]) ok = 1'b0;
        if (ok) best = l;
      end
    end
    v.expMatch  = hit;
    v.expMatchQ = hit;
    v.expProg   = best;
    v.expCount  = mCount;
  endtask

  initial begin
    vec_t v;
    bit   ovlState;

    // rst vld d ovl clr | match match_q progress count
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0));
    // overlapping 1011011
    tbl.push_back(mk(0,1,1,1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,1));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,1));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,1));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,2));
    // non-overlapping 1011011
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,0,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,0,0, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,1,0,0, 0,0,1,1));
    tbl.push_back(mk(0,1,1,0,0, 0,0,1,1));
    // KMP fallback 101011
    tbl.push_back(mk(1,0,0,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,1));
    // same stream with a three-cycle valid gap after bit 2
    tbl.push_back(mk(1,0,0,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,2,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,2,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,1));
    // reset mid-pattern, then clear coincident with a match
    tbl.push_back(mk(1,0,0,1,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(1,1,1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,1));
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,1));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,1));
    tbl.push_back(mk(0,1,1,1,1, 1,1,1,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1,0));
    // invalid final bit at P=3 must not match
    tbl.push_back(mk(0,1,0,1,0, 0,0,2,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,0,1,1,0, 0,0,3,0));
    tbl.push_back(mk(0,1,1,1,0, 1,1,1,1));
    tbl.push_back(mk(0,0,0,1,1, 0,0,1,0));

    reset = 1'b1;
    resetB = 1'b1;
    busA.din_valid = 1'b0; busA.din = 1'b0; busA.overlap = 1'b0; busA.cnt_clr = 1'b0;
    busB.din_valid = 1'b0; busB.din = 1'b0; busB.overlap = 1'b1; busB.cnt_clr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      runCycle(tbl[i], $sformatf("vec%0d", i));

    ovlState = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) ovlState = ~ovlState;
      v.rst = (i == 0) || ($urandom_range(0, 99) < 2);
      v.vld = ($urandom_range(0, 99) < 75);
      v.d   = 1'($urandom_range(0, 1));
      v.ovl = ovlState;
      v.clr = ($urandom_range(0, 49) == 0);
      modelStep(v);
      runCycle(v, $sformatf("rand%0d", i));
    end

    // 2-bit counter, pattern 11, overlapping: saturates at 3
    reset = 1'b1;
    busA.din_valid = 1'b0;
    resetB = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      busB.din_valid = 1'b1;
      busB.din = 1'b1;
      busB.overlap = 1'b1;
      busB.cnt_clr = 1'b0;
      #3;
      checkOutput($sformatf("sat%0d match", n), int'(busB.match), (n >= 2) ? 1 : 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d match_q", n), int'(busB.match_q), (n >= 2) ? 1 : 0);
      checkOutput($sformatf("sat%0d progress", n), int'(busB.progress), 1);
      checkOutput($sformatf("sat%0d match_count", n), int'(busB.match_count), (n - 1 > 3) ? 3 : n - 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
